// File: rtl/jt12_eg_sched_if.sv
// Bus between the envelope scheduler and its register interface / shared datapath.
// master: register interface + datapath side; slave: the scheduler.
interface jt12_eg_sched_if #(
    parameter int unsigned CNTW = 15
);
    logic            clk_en;
    logic            kon_we;
    logic [2:0]      kon_ch;
    logic [3:0]      kon_op;
    logic            csm_trig;
    logic [2:0]      state_next;
    logic [9:0]      eg_next;
    logic            ssg_inv_next;
    logic [4:0]      slot;
    logic [2:0]      state_cur;
    logic [9:0]      eg_cur;
    logic            ssg_inv_cur;
    logic            keyon_now;
    logic            keyoff_now;
    logic [CNTW-1:0] eg_cnt;
    logic            eg_step_en;
    logic            round_end;

    modport master (
        output clk_en, kon_we, kon_ch, kon_op, csm_trig,
        output state_next, eg_next, ssg_inv_next,
        input  slot, state_cur, eg_cur, ssg_inv_cur,
        input  keyon_now, keyoff_now, eg_cnt, eg_step_en, round_end
    );

    modport slave (
        input  clk_en, kon_we, kon_ch, kon_op, csm_trig,
        input  state_next, eg_next, ssg_inv_next,
        output slot, state_cur, eg_cur, ssg_inv_cur,
        output keyon_now, keyoff_now, eg_cnt, eg_step_en, round_end
    );
endinterface

// File: rtl/jt12_eg_sched.sv
// Envelope-generator slot scheduler: walks the operator slots round-robin,
// holds per-slot envelope state for the shared datapath, turns key-on register
// writes into per-slot key edges and paces stepping with the global eg_cnt.
// Optional CSM key-on of channel 2: define JT12_EG_SCHED_CSM_EN.
module jt12_eg_sched #(
    parameter int unsigned SLOTS = 24,
    parameter int unsigned CNTW  = 15,
    parameter int unsigned PRESC = 3
) (
    input  logic           clk,
    input  logic           rst,
    jt12_eg_sched_if.slave bus
);
    localparam int unsigned SW   = 5;
    localparam int unsigned PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned NOPS = 4;
    localparam int unsigned NCH  = 6;

    logic [SW-1:0]    r_slot;
    logic [2:0]       r_state [SLOTS];
    logic [9:0]       r_eg    [SLOTS];
    logic [SLOTS-1:0] r_ssg;
    logic [SLOTS-1:0] r_kon;
    logic [SLOTS-1:0] r_kon_prev;
    logic [CNTW-1:0]  r_eg_cnt;
    logic [PW-1:0]    r_presc;
    logic             r_step_en;

    logic             w_round_end;
    logic             w_kon_valid;
    logic [2:0]       w_chidx;
    logic [SW-1:0]    w_kon_idx [NOPS];
    logic             w_key_eff;

    assign w_round_end = (r_slot == SW'(SLOTS - 1));

    // Channel code to channel index; codes 3 and 7 are holes in the register map
    always_comb begin
        w_kon_valid = 1'b1;
        w_chidx     = 3'd0;
        case (bus.kon_ch)
            3'd0, 3'd1, 3'd2: w_chidx = bus.kon_ch;
            3'd4, 3'd5, 3'd6: w_chidx = bus.kon_ch - 3'd1;
            default:          w_kon_valid = 1'b0;
        endcase
        for (int op = 0; op < NOPS; op++) begin
            w_kon_idx[op] = SW'(op * NCH) + SW'(w_chidx);
        end
    end

`ifdef JT12_EG_SCHED_CSM_EN
    logic            r_csm_pend;
    logic [NOPS-1:0] r_csm_key;
    logic            w_csm_ch2;
    logic [1:0]      w_csm_op;
    logic            w_csm_start;

    // Locate the current slot among the four channel-2 operator slots
    always_comb begin
        w_csm_ch2 = 1'b0;
        w_csm_op  = 2'd0;
        for (int op = 0; op < NOPS; op++) begin
            if (r_slot == SW'(op * NCH + 2)) begin
                w_csm_ch2 = 1'b1;
                w_csm_op  = 2'(op);
            end
        end
    end

    assign w_csm_start = bus.clk_en && r_csm_pend && (r_slot == SW'(2)) && (r_csm_key == '0);
    // A held register key masks the CSM key, so no CSM edges appear for it
    assign w_key_eff   = r_kon[r_slot] | (w_csm_ch2 & r_csm_key[w_csm_op]);

    // CSM pass: every ch2 operator sees one visit keyed on, then one keyed off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csm_pend <= 1'b0;
            r_csm_key  <= '0;
        end else begin
            if (bus.csm_trig) begin
                r_csm_pend <= 1'b1;
            end else if (w_csm_start) begin
                r_csm_pend <= 1'b0;
            end
            if (w_csm_start) begin
                r_csm_key <= '1;
            end else if (bus.clk_en && w_csm_ch2) begin
                r_csm_key[w_csm_op] <= 1'b0;
            end
        end
    end
`else
    logic w_unused_csm;
    assign w_unused_csm = bus.csm_trig;
    assign w_key_eff    = r_kon[r_slot];
`endif

    // Slot counter and per-slot envelope storage written back by the datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_ssg  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_state[i] <= 3'b000;
                r_eg[i]    <= 10'h3FF;
            end
        end else if (bus.clk_en) begin
            r_slot          <= w_round_end ? '0 : r_slot + SW'(1);
            r_state[r_slot] <= bus.state_next;
            r_eg[r_slot]    <= bus.eg_next;
            r_ssg[r_slot]   <= bus.ssg_inv_next;
        end
    end

    // Key latch: register writes land regardless of clk_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kon <= '0;
        end else if (bus.kon_we && w_kon_valid) begin
            for (int op = 0; op < NOPS; op++) begin
                r_kon[w_kon_idx[op]] <= bus.kon_op[op];
            end
        end
    end

    // Key seen at the last visit; makes each edge last exactly one visit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kon_prev <= '0;
        end else if (bus.clk_en) begin
            r_kon_prev[r_slot] <= w_key_eff;
        end
    end

    // Round prescaler, global envelope counter and per-round step enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_eg_cnt  <= '0;
            r_step_en <= 1'b0;
        end else if (bus.clk_en && w_round_end) begin
            r_step_en <= (r_presc == PW'(PRESC - 1));
            if (r_presc == PW'(PRESC - 1)) begin
                r_presc  <= '0;
                r_eg_cnt <= r_eg_cnt + CNTW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign bus.slot        = r_slot;
    assign bus.state_cur   = r_state[r_slot];
    assign bus.eg_cur      = r_eg[r_slot];
    assign bus.ssg_inv_cur = r_ssg[r_slot];
    assign bus.keyon_now   = w_key_eff & ~r_kon_prev[r_slot];
    assign bus.keyoff_now  = ~w_key_eff & r_kon_prev[r_slot];
    assign bus.eg_cnt      = r_eg_cnt;
    assign bus.eg_step_en  = r_step_en;
    assign bus.round_end   = w_round_end;

endmodule

// File: tb/tb_jt12_eg_sched.sv
// Bench for jt12_eg_sched: directed scenarios plus random traffic, all checked
// against a slot/round arithmetic model. A second instance with a narrow
// eg_cnt exercises counter wrap within a short run.
module tb_jt12_eg_sched;
    localparam int unsigned SLOTS  = 24;
    localparam int unsigned CNTW   = 15;
    localparam int unsigned PRESC  = 3;
    localparam int unsigned CNTW_S = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jt12_eg_sched_if #(.CNTW(CNTW))   u_if   ();
    jt12_eg_sched_if #(.CNTW(CNTW_S)) u_if_s ();

    jt12_eg_sched #(.SLOTS(SLOTS), .CNTW(CNTW), .PRESC(PRESC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    jt12_eg_sched #(.SLOTS(SLOTS), .CNTW(CNTW_S), .PRESC(PRESC)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (u_if_s)
    );

    assign u_if_s.clk_en       = u_if.clk_en;
    assign u_if_s.kon_we       = u_if.kon_we;
    assign u_if_s.kon_ch       = u_if.kon_ch;
    assign u_if_s.kon_op       = u_if.kon_op;
    assign u_if_s.csm_trig     = u_if.csm_trig;
    assign u_if_s.state_next   = u_if_s.state_cur;
    assign u_if_s.eg_next      = u_if_s.eg_cur;
    assign u_if_s.ssg_inv_next = u_if_s.ssg_inv_cur;

    int n_cmp = 0;
    int n_err = 0;

    // model: clk_en cycles since reset, latched keys, key seen at last visit, storage
    int unsigned cyc;
    bit          m_kon  [SLOTS];
    bit          m_seen [SLOTS];
    logic [2:0]  m_state[SLOTS];
    logic [9:0]  m_eg   [SLOTS];
    bit          m_ssg  [SLOTS];
    int          n_on   [SLOTS];
    int          n_off  [SLOTS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int slot_of(input int op, input logic [2:0] ch);
        return op * 6 + ((ch < 3'd3) ? int'(ch) : int'(ch) - 1);
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < SLOTS; i++) begin
            m_kon[i]   = 1'b0;
            m_seen[i]  = 1'b0;
            m_state[i] = 3'b000;
            m_eg[i]    = 10'h3FF;
            m_ssg[i]   = 1'b0;
        end
    endtask

    task automatic clear_tally();
        for (int i = 0; i < SLOTS; i++) begin
            n_on[i]  = 0;
            n_off[i] = 0;
        end
    endtask

    task automatic check_all();
        int unsigned s;
        int unsigned r;
        s = cyc % SLOTS;
        r = cyc / SLOTS;
        chk("slot",        32'(u_if.slot),        32'(s));
        chk("state_cur",   32'(u_if.state_cur),   32'(m_state[s]));
        chk("eg_cur",      32'(u_if.eg_cur),      32'(m_eg[s]));
        chk("ssg_inv_cur", 32'(u_if.ssg_inv_cur), 32'(m_ssg[s]));
        chk("keyon_now",   32'(u_if.keyon_now),   32'(m_kon[s] & ~m_seen[s]));
        chk("keyoff_now",  32'(u_if.keyoff_now),  32'(~m_kon[s] & m_seen[s]));
        chk("eg_cnt",      32'(u_if.eg_cnt),      32'((r / PRESC) % (1 << CNTW)));
        chk("eg_cnt_narrow", 32'(u_if_s.eg_cnt),  32'((r / PRESC) % (1 << CNTW_S)));
        chk("eg_step_en",  32'(u_if.eg_step_en),  32'(r > 0 && (r % PRESC) == 0));
        chk("round_end",   32'(u_if.round_end),   32'(s == SLOTS - 1));
        if (u_if.keyon_now === 1'b1)  n_on[s]++;
        if (u_if.keyoff_now === 1'b1) n_off[s]++;
    endtask

    // one clock: drive inputs, let the edge happen, advance model, check at negedge
    // dp: 0 passthrough, 1 random datapath + random csm_trig, 2 passthrough with eg_next=040
    task automatic step(input bit en, input bit we, input logic [2:0] ch,
                        input logic [3:0] op, input int dp);
        int unsigned s;
        s = cyc % SLOTS;
        u_if.clk_en   = en;
        u_if.kon_we   = we;
        u_if.kon_ch   = ch;
        u_if.kon_op   = op;
        u_if.csm_trig = 1'b0;
        u_if.state_next   = m_state[s];
        u_if.eg_next      = m_eg[s];
        u_if.ssg_inv_next = m_ssg[s];
        if (dp == 1) begin
            u_if.state_next   = 3'($urandom);
            u_if.eg_next      = 10'($urandom);
            u_if.ssg_inv_next = 1'($urandom);
            u_if.csm_trig     = ($urandom_range(0, 7) == 0);
        end else if (dp == 2) begin
            u_if.eg_next = 10'h040;
        end
        @(posedge clk);
        if (en) begin
            m_seen[s]  = m_kon[s];
            m_state[s] = u_if.state_next;
            m_eg[s]    = u_if.eg_next;
            m_ssg[s]   = u_if.ssg_inv_next;
            cyc++;
        end
        if (we && ch != 3'd3 && ch != 3'd7) begin
            for (int o = 0; o < 4; o++) m_kon[slot_of(o, ch)] = op[o];
        end
        @(negedge clk);
        u_if.kon_we   = 1'b0;
        u_if.csm_trig = 1'b0;
        check_all();
    endtask

    task automatic run_to_slot(input int unsigned target);
        for (int i = 0; i < SLOTS && (cyc % SLOTS) != target; i++) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("run_to_slot", 32'(u_if.slot), 32'(target));
    endtask

    // asserted away from the clock edge to show the reset acts immediately
    task automatic do_reset();
        u_if.clk_en = 1'b0;
        u_if.kon_we = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_slot",   32'(u_if.slot),   32'd0);
        chk("rst_eg_cnt", 32'(u_if.eg_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        u_if.clk_en       = 1'b0;
        u_if.kon_we       = 1'b0;
        u_if.kon_ch       = 3'd0;
        u_if.kon_op       = 4'd0;
        u_if.csm_trig     = 1'b0;
        u_if.state_next   = 3'd0;
        u_if.eg_next      = 10'h3FF;
        u_if.ssg_inv_next = 1'b0;
        model_reset();
        clear_tally();

        @(negedge clk);
        do_reset();

        // one quiet round with the datapath holding every slot
        repeat (SLOTS) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("quiet_wrap_slot", 32'(u_if.slot), 32'd0);

        // key on ch code 4, ops 0 and 2 -> slots 3 and 15, once each
        clear_tally();
        step(1'b1, 1'b1, 3'd4, 4'b0101, 0);
        repeat (2 * SLOTS) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("keyon_once_s3",  32'(n_on[3]),  32'd1);
        chk("keyon_once_s15", 32'(n_on[15]), 32'd1);
        chk("keyon_none_s9",  32'(n_on[9]),  32'd0);

        clear_tally();
        step(1'b1, 1'b1, 3'd4, 4'b0000, 0);
        repeat (2 * SLOTS) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("keyoff_once_s3",  32'(n_off[3]),  32'd1);
        chk("keyoff_once_s15", 32'(n_off[15]), 32'd1);

        // write landing on the very clock slot 3 is visited
        run_to_slot(3);
        chk("same_clk_no_edge", 32'(u_if.keyon_now), 32'd0);
        step(1'b1, 1'b1, 3'd4, 4'b0001, 0);
        clear_tally();
        repeat (SLOTS - 1) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("same_clk_next_round", 32'(n_on[3]), 32'd1);
        step(1'b1, 1'b0, 3'd0, 4'd0, 0);

        // off then back on before the next visit: no edge at all
        clear_tally();
        step(1'b1, 1'b1, 3'd4, 4'b0000, 0);
        step(1'b1, 1'b1, 3'd4, 4'b0001, 0);
        repeat (SLOTS) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("revert_no_on",  32'(n_on[3]),  32'd0);
        chk("revert_no_off", 32'(n_off[3]), 32'd0);

        // invalid channel codes change nothing
        clear_tally();
        step(1'b1, 1'b1, 3'd3, 4'b1111, 0);
        step(1'b1, 1'b1, 3'd7, 4'b1111, 0);
        repeat (SLOTS) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("invalid_ch_no_edge", 32'(n_on[2] + n_on[3] + n_on[5]), 32'd0);

        // clk_en gap mid-round with a key write captured inside it
        run_to_slot(10);
        clear_tally();
        step(1'b0, 1'b0, 3'd0, 4'd0, 1);
        step(1'b0, 1'b1, 3'd0, 4'b1111, 1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1);
        chk("gap_frozen_slot", 32'(u_if.slot), 32'd10);
        repeat (SLOTS) step(1'b1, 1'b0, 3'd0, 4'd0, 0);
        chk("gap_kon_s12", 32'(n_on[12]), 32'd1);
        chk("gap_kon_s0",  32'(n_on[0]),  32'd1);

        // reset mid-round after slot 5 took a new attenuation
        run_to_slot(5);
        step(1'b1, 1'b0, 3'd0, 4'd0, 2);
        run_to_slot(17);
        do_reset();
        run_to_slot(5);
        chk("rst_eg_slot5", 32'(u_if.eg_cur), 32'h3FF);

        // random traffic, long enough to wrap the narrow counter
        for (int i = 0; i < 3000 && cyc < 1300; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0),
                 3'($urandom), 4'($urandom), 1);
        end
        chk("narrow_wrapped", 32'(cyc >= (1 << CNTW_S) * PRESC * SLOTS), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
